// File: rtl/bip_pkg.sv
// bip_pkg
//   Shared definitions for the BIP fetch stage.
//   - NB_OPCODE / OPC_HLT : opcode field width and the halt opcode
//   - fetch_state_t       : fetch FSM states
//   - get_opcode()        : extracts the opcode field from an instruction word
package bip_pkg;

    localparam int NB_OPCODE = 5;
    localparam logic [NB_OPCODE-1:0] OPC_HLT = 5'b00000;

    // Widest instruction word / opcode field the extraction helper accepts.
    // Callers zero-extend their word into WORD_MAX bits.
    localparam int WORD_MAX   = 64;
    localparam int OPCODE_MAX = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Returns the top nb_opc bits of an nb_word-bit instruction, right-aligned
    // and zero-extended to OPCODE_MAX bits, so any instantiation width works.
    function automatic logic [OPCODE_MAX-1:0] get_opcode(
        input logic [WORD_MAX-1:0] word,
        input int                  nb_word,
        input int                  nb_opc
    );
        logic [WORD_MAX-1:0]   shifted;
        logic [OPCODE_MAX-1:0] ones;
        logic [OPCODE_MAX-1:0] mask;
        shifted = word >> (nb_word - nb_opc);
        ones    = '1;
        mask    = ~(ones << nb_opc);
        return shifted[OPCODE_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/bip_program_counter.sv
// bip_program_counter
//   Program counter of the fetch stage: clears to zero, advances by one when
//   enabled and wraps modulo 2^NB_ADDRESS.
//   Ports:
//     clock   : rising-edge clock
//     reset   : synchronous, active-high reset (address -> 0)
//     clear   : synchronous load of zero (wins over enable)
//     enable  : advance the counter by one
//     address : current program counter
module bip_program_counter #(
    parameter int NB_ADDRESS = 11
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    output logic [NB_ADDRESS-1:0] address
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            address <= '0;
        end else if (enable) begin
            // natural overflow gives the modulo-2^NB_ADDRESS wrap
            address <= address + 1'b1;
        end
    end

endmodule

// File: rtl/bip_fetch_unit.sv
// bip_fetch_unit
//   Instruction fetch stage of the BIP processor. Drives the program counter
//   to a combinational program memory, registers the returned word and flags
//   it with a one-cycle valid strobe. Stops on the HLT opcode, supports
//   free-run and single-step, and counts fetches since the last start.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | after reset, waiting for i_start
//   RUN    | fetching; one fetch per cycle, or per i_step in step mode
//   HALTED | HLT fetched; everything frozen until the next i_start
//
//   Ports:
//     i_clock        : rising-edge clock
//     i_reset        : synchronous, active-high reset
//     i_start        : pulse, start execution at address 0 (IDLE/HALTED only)
//     i_step_mode    : 1 = single-step, 0 = free-run
//     i_step         : pulse, allows one fetch in step mode
//     i_instruction  : program memory data for o_address
//     o_address      : program counter
//     o_instruction  : last fetched instruction
//     o_valid        : o_instruction was fetched at the last edge
//     o_busy         : state is RUN
//     o_halted       : state is HALTED
//     o_fetch_count  : fetches since last start, saturating
module bip_fetch_unit #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_ADDRESS     = 11,
    parameter int NB_OPCODE      = 5,
    parameter int NB_COUNT       = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_step_mode,
    input  logic                      i_step,
    input  logic [NB_INSTRUCTION-1:0] i_instruction,
    output logic [NB_ADDRESS-1:0]     o_address,
    output logic [NB_INSTRUCTION-1:0] o_instruction,
    output logic                      o_valid,
    output logic                      o_busy,
    output logic                      o_halted,
    output logic [NB_COUNT-1:0]       o_fetch_count
);
    import bip_pkg::*;

    localparam logic [OPCODE_MAX-1:0] OPC_HLT_EXT = OPCODE_MAX'(OPC_HLT);

    fetch_state_t              state;
    fetch_state_t              state_next;
    logic                      adv;
    logic                      is_hlt;
    logic                      launch;
    logic                      fetch;
    logic                      pc_enable;
    logic [WORD_MAX-1:0]       instr_ext;
    logic [NB_INSTRUCTION-1:0] instr_q;
    logic                      valid_q;
    logic [NB_COUNT-1:0]       count_q;

    assign adv = !i_step_mode || i_step;

    always_comb begin
        instr_ext = '0;
        instr_ext[NB_INSTRUCTION-1:0] = i_instruction;
    end

    assign is_hlt = (get_opcode(instr_ext, NB_INSTRUCTION, NB_OPCODE) == OPC_HLT_EXT);

    // state register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) state_next = RUN;
            end
            RUN: begin
                if (adv && is_hlt) state_next = HALTED;
            end
            HALTED: begin
                if (i_start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // control strobes for the datapath
    always_comb begin
        launch = 1'b0;
        fetch  = 1'b0;
        case (state)
            IDLE, HALTED: launch = i_start;
            RUN:          fetch  = adv;
            default: begin
                launch = 1'b0;
                fetch  = 1'b0;
            end
        endcase
    end

    // the PC parks on the HLT word so o_address keeps pointing at it
    assign pc_enable = fetch && !is_hlt;

    bip_program_counter #(
        .NB_ADDRESS (NB_ADDRESS)
    ) u_program_counter (
        .clock   (i_clock),
        .reset   (i_reset),
        .clear   (launch),
        .enable  (pc_enable),
        .address (o_address)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            valid_q <= fetch;
            if (fetch) begin
                instr_q <= i_instruction;
            end
            if (launch) begin
                count_q <= '0;
            end else if (fetch && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign o_instruction = instr_q;
    assign o_valid       = valid_q;
    assign o_fetch_count = count_q;
    assign o_busy        = (state == RUN);
    assign o_halted      = (state == HALTED);

endmodule

// File: tb/tb_bip_fetch_unit.sv
module tb_bip_fetch_unit;

    localparam int  DEPTH   = 2048;
    localparam int  M_IDLE  = 0;
    localparam int  M_RUN   = 1;
    localparam int  M_HALT  = 2;
    localparam longint CNT_MAX = 64'hFFFF_FFFF;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        i_step_mode;
    logic        i_step;
    logic [15:0] i_instruction;
    logic [10:0] o_address;
    logic [15:0] o_instruction;
    logic        o_valid;
    logic        o_busy;
    logic        o_halted;
    logic [31:0] o_fetch_count;

    logic [15:0] mem [DEPTH];

    always #5 i_clock = ~i_clock;

    assign i_instruction = mem[o_address];

    bip_fetch_unit dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_step_mode   (i_step_mode),
        .i_step        (i_step),
        .i_instruction (i_instruction),
        .o_address     (o_address),
        .o_instruction (o_instruction),
        .o_valid       (o_valid),
        .o_busy        (o_busy),
        .o_halted      (o_halted),
        .o_fetch_count (o_fetch_count)
    );

    int checks = 0;
    int errors = 0;

    // reference model: what the fetch stage should be showing
    int          m_mode;
    int          m_pc;
    longint      m_cnt;
    logic [15:0] m_instr;
    bit          m_valid;

    logic [15:0] seen[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit st, input bit sm, input bit sp);
        if (rst) begin
            m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_instr = '0; m_valid = 0;
            return;
        end
        m_valid = 0;
        if (m_mode != M_RUN) begin
            if (st) begin
                m_mode = M_RUN; m_pc = 0; m_cnt = 0;
            end
        end else if (!sm || sp) begin
            m_instr = mem[m_pc];
            m_valid = 1;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if ((m_instr >> 11) == 0) m_mode = M_HALT;
            else m_pc = (m_pc + 1) % DEPTH;
        end
    endtask

    task automatic tick(input bit rst, input bit st, input bit sm, input bit sp);
        i_reset = rst; i_start = st; i_step_mode = sm; i_step = sp;
        model_step(rst, st, sm, sp);
        @(posedge i_clock);
        #1;
        check("address",     o_address,     m_pc);
        check("instruction", o_instruction, m_instr);
        check("valid",       o_valid,       m_valid);
        check("busy",        o_busy,        m_mode == M_RUN);
        check("halted",      o_halted,      m_mode == M_HALT);
        check("fetch_count", o_fetch_count, m_cnt);
        if (o_valid) seen.push_back(o_instruction);
    endtask

    task automatic load_program();
        for (int a = 0; a < DEPTH; a++) mem[a] = 16'h0800 | 16'($urandom_range(16'h0000, 16'hF7FF));
        mem[0] = 16'h0801; mem[1] = 16'h1002; mem[2] = 16'h1803; mem[3] = 16'h0000;
    endtask

    initial begin
        logic [15:0] prog [4];
        int          nvalid;
        prog[0] = 16'h0801; prog[1] = 16'h1002; prog[2] = 16'h1803; prog[3] = 16'h0000;
        i_reset = 1'b1; i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
        load_program();
        m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_instr = '0; m_valid = 0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
            check("rst_valid", o_valid, 0);
        end

        // free-run program ending in HLT
        tick(0, 0, 0, 0);
        seen.delete();
        tick(0, 1, 0, 0);
        check("start_busy", o_busy, 1);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 0);
        check("free_nwords", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) check("free_word", seen[i], prog[i]);
        check("free_count", o_fetch_count, 4);
        check("free_addr",  o_address, 3);
        check("free_halt",  o_halted, 1);

        // single-step, pulses 5 cycles apart (5th pulse after halt is ignored)
        seen.delete();
        tick(0, 1, 1, 0);
        for (int p = 0; p < 5; p++) begin
            tick(0, 0, 1, 1);
            for (int k = 0; k < 4; k++) tick(0, 0, 1, 0);
        end
        check("step_nwords", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) check("step_word", seen[i], prog[i]);
        check("step_halt",  o_halted, 1);
        check("step_count", o_fetch_count, 4);

        // no HLT: wrap the PC, with a start pulse ignored mid-run
        for (int a = 0; a < DEPTH; a++) mem[a] = 16'h0800 | 16'($urandom_range(16'h0000, 16'hF7FF));
        tick(0, 1, 0, 0);
        nvalid = 0;
        for (int i = 0; i < 2049; i++) begin
            tick(0, (i == 100), 0, 0);
            if (i == 2047) check("wrap_addr0", o_address, 0);
        end
        check("wrap_count", o_fetch_count, 2049);
        check("wrap_addr",  o_address, 1);

        // reset in the middle of RUN
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("midrst_addr",  o_address, 0);
        check("midrst_instr", o_instruction, 0);
        check("midrst_count", o_fetch_count, 0);
        check("midrst_busy",  o_busy, 0);

        // restart after halt
        load_program();
        tick(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
        check("re_halt", o_halted, 1);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        check("re_count", o_fetch_count, 1);
        check("re_instr", o_instruction, 16'h0801);
        check("re_addr",  o_address, 1);

        // random traffic over a memory with sparse HLT words
        for (int a = 0; a < DEPTH; a++) begin
            mem[a] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) mem[a] = mem[a] & 16'h07FF;
        end
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
